// File: rtl/agc_stats_accum.sv
// Per-window AGC statistics: sum of |x|^2 plus gt/lt flag counts over 2^PERIOD_LOG2 clocks; results 4 cycles after last sample.
// No backpressure: inputs are consumed every clock, and start_i is ignored while busy_o or done_o is high.
module agc_stats_accum #(
  parameter int NSAMP       = 8,
  parameter int ABS_BITS    = 4,
  parameter int PERIOD_LOG2 = 16,
  parameter int SQ_ACC_BITS = 32,
  parameter int CNT_BITS    = 24
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic [NSAMP*ABS_BITS-1:0] abs_i,
  input  logic [NSAMP-1:0]          gt_i,
  input  logic [NSAMP-1:0]          lt_i,
  input  logic                      start_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      valid_o,
  output logic [SQ_ACC_BITS-1:0]    sq_sum_o,
  output logic [CNT_BITS-1:0]       gt_count_o,
  output logic [CNT_BITS-1:0]       lt_count_o
);
  localparam int LSQ_W      = 2 * ABS_BITS;
  localparam int SQ_TREE_W  = LSQ_W + $clog2(NSAMP);
  localparam int CNT_TREE_W = $clog2(NSAMP + 1);
  localparam int SQ_SUM_W   = ((SQ_ACC_BITS > SQ_TREE_W) ? SQ_ACC_BITS : SQ_TREE_W) + 1;
  localparam int CNT_SUM_W  = ((CNT_BITS > CNT_TREE_W) ? CNT_BITS : CNT_TREE_W) + 1;
  localparam logic [SQ_SUM_W-1:0]  SQ_MAX  = (SQ_SUM_W'(1) << SQ_ACC_BITS) - SQ_SUM_W'(1);
  localparam logic [CNT_SUM_W-1:0] CNT_MAX = (CNT_SUM_W'(1) << CNT_BITS) - CNT_SUM_W'(1);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

  state_t                 state, state_nxt;
  logic [PERIOD_LOG2-1:0] win_cnt;
  logic [1:0]             drain_cnt;
  logic                   clear, drain_exit;
  logic [1:0]             rst_sync;
  logic                   rst_n;

  // Reset asserts asynchronously but releases two clocks after rst_n_i rises.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) rst_sync <= '0;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      win_cnt   <= '0;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      win_cnt   <= (state == ACCUM) ? win_cnt + PERIOD_LOG2'(1) : '0;
      drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : '0;
    end
  end

  always_comb begin
    state_nxt  = state;
    clear      = 1'b0;
    drain_exit = 1'b0;
    case (state)
      IDLE:  if (start_i && !done_o) begin
               clear     = 1'b1;
               state_nxt = ACCUM;
             end
      ACCUM: if (&win_cnt) state_nxt = DRAIN;
      DRAIN: if (drain_cnt == 2'd2) begin
               drain_exit = 1'b1;
               state_nxt  = IDLE;
             end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy_o = (state != IDLE);

  logic [NSAMP*ABS_BITS-1:0] s1_abs;
  logic [NSAMP-1:0]          s1_gt, s1_lt;
  logic [NSAMP*LSQ_W-1:0]    sq_lane, s2_sq;
  logic [CNT_TREE_W-1:0]     gt_pop, lt_pop, s2_gt, s2_lt, s3_gt, s3_lt;
  logic [SQ_TREE_W-1:0]      sq_tree, s3_sq;
  logic                      s1_win, s2_win, s3_win;

  // The 4-bit self-product reduces to a 16-entry constant table per lane.
  always_comb begin
    sq_lane = '0;
    gt_pop  = '0;
    lt_pop  = '0;
    for (int k = 0; k < NSAMP; k++) begin
      sq_lane[k*LSQ_W +: LSQ_W] = LSQ_W'(s1_abs[k*ABS_BITS +: ABS_BITS]) *
                                  LSQ_W'(s1_abs[k*ABS_BITS +: ABS_BITS]);
      gt_pop = gt_pop + CNT_TREE_W'(s1_gt[k]);
      lt_pop = lt_pop + CNT_TREE_W'(s1_lt[k]);
    end
  end

  always_comb begin
    sq_tree = '0;
    for (int k = 0; k < NSAMP; k++)
      sq_tree = sq_tree + SQ_TREE_W'(s2_sq[k*LSQ_W +: LSQ_W]);
  end

  // The window tag travels with each sample so the pipeline delay never shifts the window.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      s1_abs <= '0; s1_gt <= '0; s1_lt <= '0; s1_win <= 1'b0;
      s2_sq  <= '0; s2_gt <= '0; s2_lt <= '0; s2_win <= 1'b0;
      s3_sq  <= '0; s3_gt <= '0; s3_lt <= '0; s3_win <= 1'b0;
    end else begin
      s1_abs <= abs_i;   s1_gt <= gt_i;   s1_lt <= lt_i;   s1_win <= (state == ACCUM);
      s2_sq  <= sq_lane; s2_gt <= gt_pop; s2_lt <= lt_pop; s2_win <= s1_win;
      s3_sq  <= sq_tree; s3_gt <= s2_gt;  s3_lt <= s2_lt;  s3_win <= s2_win;
    end
  end

  logic [SQ_ACC_BITS-1:0] sq_acc, sq_nxt;
  logic [CNT_BITS-1:0]    gt_acc, lt_acc, gt_nxt, lt_nxt;
  logic [SQ_SUM_W-1:0]    sq_wide;
  logic [CNT_SUM_W-1:0]   gt_wide, lt_wide;

  assign sq_wide = SQ_SUM_W'(sq_acc) + SQ_SUM_W'(s3_sq);
  assign gt_wide = CNT_SUM_W'(gt_acc) + CNT_SUM_W'(s3_gt);
  assign lt_wide = CNT_SUM_W'(lt_acc) + CNT_SUM_W'(s3_lt);

  always_comb begin
    sq_nxt = sq_acc;
    gt_nxt = gt_acc;
    lt_nxt = lt_acc;
    if (clear) begin
      sq_nxt = '0;
      gt_nxt = '0;
      lt_nxt = '0;
    end else if (s3_win) begin
      sq_nxt = (sq_wide > SQ_MAX)  ? '1 : sq_wide[SQ_ACC_BITS-1:0];
      gt_nxt = (gt_wide > CNT_MAX) ? '1 : gt_wide[CNT_BITS-1:0];
      lt_nxt = (lt_wide > CNT_MAX) ? '1 : lt_wide[CNT_BITS-1:0];
    end
  end

  // Outputs take the next-state sums so the final sample lands in the same edge as done_o.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      sq_acc <= '0; gt_acc <= '0; lt_acc <= '0;
      sq_sum_o <= '0; gt_count_o <= '0; lt_count_o <= '0;
      done_o <= 1'b0;
      valid_o <= 1'b0;
    end else begin
      sq_acc <= sq_nxt;
      gt_acc <= gt_nxt;
      lt_acc <= lt_nxt;
      done_o <= drain_exit;
      if (clear) valid_o <= 1'b0;
      if (drain_exit) begin
        sq_sum_o   <= sq_nxt;
        gt_count_o <= gt_nxt;
        lt_count_o <= lt_nxt;
        valid_o    <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_agc_stats_accum.sv
// Bench for agc_stats_accum: a default-width DUT and a narrow-accumulator DUT share stimulus, 16-cycle windows.
module tb_agc_stats_accum;
  localparam int NS  = 8;
  localparam int AB  = 4;
  localparam int WIN = 16;
  localparam int TOT = 24;
  localparam longint SQ_MAX   = 64'hFFFF_FFFF;
  localparam longint CNT_MAX  = 64'hFF_FFFF;
  localparam longint SQ_MAXS  = 1023;
  localparam longint CNT_MAXS = 63;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [NS*AB-1:0] abs_v;
  logic [NS-1:0]    gt_v, lt_v;
  logic             start;
  logic             busy, done, valid, busy_s, done_s, valid_s;
  logic [31:0]      sq;
  logic [23:0]      gtc, ltc;
  logic [9:0]       sq_s;
  logic [5:0]       gtc_s, ltc_s;

  agc_stats_accum #(.NSAMP(NS), .ABS_BITS(AB), .PERIOD_LOG2(4), .SQ_ACC_BITS(32), .CNT_BITS(24)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .abs_i(abs_v), .gt_i(gt_v), .lt_i(lt_v), .start_i(start),
    .busy_o(busy), .done_o(done), .valid_o(valid),
    .sq_sum_o(sq), .gt_count_o(gtc), .lt_count_o(ltc));

  agc_stats_accum #(.NSAMP(NS), .ABS_BITS(AB), .PERIOD_LOG2(4), .SQ_ACC_BITS(10), .CNT_BITS(6)) dut_sat (
    .clk_i(clk), .rst_n_i(rst_n), .abs_i(abs_v), .gt_i(gt_v), .lt_i(lt_v), .start_i(start),
    .busy_o(busy_s), .done_o(done_s), .valid_o(valid_s),
    .sq_sum_o(sq_s), .gt_count_o(gtc_s), .lt_count_o(ltc_s));

  int checks = 0;
  int errors = 0;

  // Index 0 is the start cycle; indices 1..WIN are the window.
  logic [NS*AB-1:0] st_abs[TOT];
  logic [NS-1:0]    st_gt[TOT], st_lt[TOT];
  logic             st_start[TOT];
  logic             ob_done[TOT], ob_valid[TOT], ob_busy[TOT], ob_done_s[TOT];
  logic [31:0]      ob_sq[TOT];
  logic [23:0]      ob_gt[TOT], ob_lt[TOT];
  logic [9:0]       ob_sq_s[TOT];
  logic [5:0]       ob_gt_s[TOT], ob_lt_s[TOT];
  longint           prev_sq, prev_gt, prev_lt;

  function automatic longint model_sq(input longint maxv);
    longint t = 0;
    for (int i = 1; i <= WIN; i++)
      for (int k = 0; k < NS; k++) begin
        longint a;
        a = longint'(st_abs[i][k*AB +: AB]);
        t += a * a;
      end
    return (t > maxv) ? maxv : t;
  endfunction

  function automatic longint model_cnt(input bit use_gt, input longint maxv);
    longint t = 0;
    for (int i = 1; i <= WIN; i++)
      t += use_gt ? $countones(st_gt[i]) : $countones(st_lt[i]);
    return (t > maxv) ? maxv : t;
  endfunction

  task automatic fill(input bit rnd, input logic [NS*AB-1:0] a, input logic [NS-1:0] g, input logic [NS-1:0] l);
    for (int i = 0; i < TOT; i++) begin
      st_abs[i]   = rnd ? (NS*AB)'($urandom) : a;
      st_gt[i]    = rnd ? NS'($urandom) : g;
      st_lt[i]    = rnd ? NS'($urandom) : l;
      st_start[i] = (i == 0);
    end
  endtask

  task automatic drive(input logic [NS*AB-1:0] a, input logic [NS-1:0] g, input logic [NS-1:0] l, input logic s);
    abs_v = a; gt_v = g; lt_v = l; start = s;
    @(posedge clk); #1;
  endtask

  task automatic run_seq();
    for (int i = 0; i < TOT; i++) begin
      abs_v = st_abs[i]; gt_v = st_gt[i]; lt_v = st_lt[i]; start = st_start[i];
      ob_done[i] = done; ob_valid[i] = valid; ob_busy[i] = busy;
      ob_sq[i] = sq; ob_gt[i] = gtc; ob_lt[i] = ltc;
      ob_done_s[i] = done_s; ob_sq_s[i] = sq_s; ob_gt_s[i] = gtc_s; ob_lt_s[i] = ltc_s;
      @(posedge clk); #1;
    end
    abs_v = '0; gt_v = '0; lt_v = '0; start = 1'b0;
  endtask

  function automatic int done_pulses();
    int n = 0;
    for (int i = 0; i < TOT; i++) n += int'(ob_done[i]);
    return n;
  endfunction

  task automatic check_results(input string tag);
    checks++; if (done_pulses() !== 1 || ob_done[20] !== 1'b1) begin errors++;
      $display("FAIL %s_done: pulses %0d at20=%b required 1 at index 20", tag, done_pulses(), ob_done[20]); end
    checks++; if (ob_sq[20] !== 32'(model_sq(SQ_MAX))) begin errors++;
      $display("FAIL %s_sq: got %0d required %0d", tag, ob_sq[20], model_sq(SQ_MAX)); end
    checks++; if (ob_gt[20] !== 24'(model_cnt(1, CNT_MAX)) || ob_lt[20] !== 24'(model_cnt(0, CNT_MAX))) begin errors++;
      $display("FAIL %s_cnt: gt %0d lt %0d required %0d %0d", tag, ob_gt[20], ob_lt[20], model_cnt(1, CNT_MAX), model_cnt(0, CNT_MAX)); end
    checks++; if (ob_sq_s[20] !== 10'(model_sq(SQ_MAXS)) || ob_gt_s[20] !== 6'(model_cnt(1, CNT_MAXS)) ||
                  ob_lt_s[20] !== 6'(model_cnt(0, CNT_MAXS)) || ob_done_s[20] !== 1'b1) begin errors++;
      $display("FAIL %s_narrow: sq %0d gt %0d lt %0d done %b required %0d %0d %0d 1", tag, ob_sq_s[20], ob_gt_s[20],
               ob_lt_s[20], ob_done_s[20], model_sq(SQ_MAXS), model_cnt(1, CNT_MAXS), model_cnt(0, CNT_MAXS)); end
    checks++; if (ob_valid[20] !== 1'b1 || ob_busy[1] !== 1'b1 || ob_busy[0] !== 1'b0 || ob_busy[20] !== 1'b0) begin errors++;
      $display("FAIL %s_status: valid20 %b busy0 %b busy1 %b busy20 %b required 1 0 1 0", tag, ob_valid[20], ob_busy[0], ob_busy[1], ob_busy[20]); end
    prev_sq = model_sq(SQ_MAX); prev_gt = model_cnt(1, CNT_MAX); prev_lt = model_cnt(0, CNT_MAX);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; abs_v = '0; gt_v = '0; lt_v = '0; start = 1'b0;
    repeat (3) @(posedge clk); #1;
    checks++; if ({busy, done, valid, busy_s, done_s, valid_s} !== 6'b0) begin errors++;
      $display("FAIL reset_flags: got %b required 000000", {busy, done, valid, busy_s, done_s, valid_s}); end
    checks++; if (sq !== '0 || gtc !== '0 || ltc !== '0 || sq_s !== '0 || gtc_s !== '0 || ltc_s !== '0) begin errors++;
      $display("FAIL reset_outputs: sq %0d gt %0d lt %0d required 0", sq, gtc, ltc); end
    rst_n = 1'b1;
    repeat (4) drive('0, '0, '0, 1'b0);
  endtask

  task automatic test_constant();
    fill(1'b0, {NS{4'd3}}, '0, '0);
    run_seq();
    checks++; if (ob_sq[20] !== 32'd1152) begin errors++;
      $display("FAIL const_sq_literal: got %0d required 1152", ob_sq[20]); end
    check_results("const");
  endtask

  task automatic test_alignment();
    fill(1'b0, '0, '0, '0);
    st_abs[0] = 32'hF; st_abs[17] = 32'hF;
    for (int i = 1; i <= WIN; i++) st_abs[i] = 32'h1;
    run_seq();
    checks++; if (ob_sq[20] !== 32'd16) begin errors++;
      $display("FAIL align_sq_literal: got %0d required 16", ob_sq[20]); end
    check_results("align");
  endtask

  task automatic test_flags();
    fill(1'b0, '0, 8'hFF, 8'h01);
    for (int i = 0; i < TOT; i++) st_abs[i] = (NS*AB)'($urandom);
    run_seq();
    checks++; if (ob_gt[20] !== 24'd128 || ob_lt[20] !== 24'd16) begin errors++;
      $display("FAIL flags_literal: gt %0d lt %0d required 128 16", ob_gt[20], ob_lt[20]); end
    check_results("flags");
  endtask

  task automatic test_ignored_start();
    fill(1'b1, '0, '0, '0);
    st_start[5] = 1'b1; st_start[20] = 1'b1;
    run_seq();
    check_results("ignored");
    checks++; if (ob_busy[21] !== 1'b0 || ob_busy[23] !== 1'b0 || ob_valid[21] !== 1'b1) begin errors++;
      $display("FAIL ignored_restart: busy21 %b busy23 %b valid21 %b required 0 0 1", ob_busy[21], ob_busy[23], ob_valid[21]); end
  endtask

  task automatic test_saturation();
    fill(1'b0, {NS{4'hF}}, 8'hFF, '0);
    run_seq();
    checks++; if (ob_gt_s[20] !== 6'd63 || ob_sq_s[20] !== 10'd1023) begin errors++;
      $display("FAIL sat_literal: gt %0d sq %0d required 63 1023", ob_gt_s[20], ob_sq_s[20]); end
    checks++; if (ob_gt[20] !== 24'd128 || ob_sq[20] !== 32'd28800) begin errors++;
      $display("FAIL sat_wide_literal: gt %0d sq %0d required 128 28800", ob_gt[20], ob_sq[20]); end
    check_results("sat");
  endtask

  task automatic test_back_to_back();
    for (int w = 0; w < 4; w++) begin
      longint hs = prev_sq, hg = prev_gt, hl = prev_lt;
      fill(1'b1, '0, '0, '0);
      run_seq();
      checks++; if (ob_sq[19] !== 32'(hs) || ob_gt[19] !== 24'(hg) || ob_lt[19] !== 24'(hl)) begin errors++;
        $display("FAIL b2b_hold%0d: sq %0d gt %0d lt %0d required %0d %0d %0d", w, ob_sq[19], ob_gt[19], ob_lt[19], hs, hg, hl); end
      checks++; if (ob_valid[0] !== 1'b1 || ob_valid[1] !== 1'b0 || ob_valid[19] !== 1'b0) begin errors++;
        $display("FAIL b2b_valid%0d: v0 %b v1 %b v19 %b required 1 0 0", w, ob_valid[0], ob_valid[1], ob_valid[19]); end
      check_results("b2b");
    end
  endtask

  task automatic test_reset_mid();
    fill(1'b1, '0, '0, '0);
    for (int i = 0; i < 9; i++) drive(st_abs[i], st_gt[i], st_lt[i], st_start[i]);
    rst_n = 1'b0;
    #1;
    checks++; if ({busy, done, valid, busy_s, valid_s} !== 5'b0) begin errors++;
      $display("FAIL midreset_flags: got %b required 00000", {busy, done, valid, busy_s, valid_s}); end
    checks++; if (sq !== '0 || gtc !== '0 || ltc !== '0 || sq_s !== '0) begin errors++;
      $display("FAIL midreset_outputs: sq %0d gt %0d lt %0d required 0", sq, gtc, ltc); end
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) drive('0, '0, '0, 1'b0);
    fill(1'b1, '0, '0, '0);
    run_seq();
    check_results("postreset");
  endtask

  initial begin
    prev_sq = 0; prev_gt = 0; prev_lt = 0;
    test_reset();
    test_constant();
    test_alignment();
    test_flags();
    test_ignored_start();
    test_saturation();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
